// File: rtl/virtual_slave_bfm_pkg.sv
// Shared types and helpers for the virtual slave register-window endpoint.
package virtual_slave_bfm_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StStrobe,
    StResp
  } state_e;

  // True when addr falls inside the 2^bits-byte window that contains base.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                    input int unsigned bits);
    return (addr >> bits) == (base >> bits);
  endfunction

endpackage

// File: rtl/virtual_slave_bfm_if.sv
// Single-beat request/response bus between a bus master and the virtual slave.
interface virtual_slave_bfm_if;

  logic                                      req_valid;
  logic                                      req_ready;
  logic                                      req_write;
  logic [31:0]                               req_addr;
  logic [virtual_slave_bfm_pkg::DATA_W-1:0] req_wdata;
  logic                                      rsp_valid;
  logic                                      rsp_ready;
  logic                                      rsp_err;
  logic [virtual_slave_bfm_pkg::DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );

endinterface

// File: rtl/virtual_slave_bfm.sv
// Address-windowed slave: turns one bus request into a one-cycle register-file
// strobe, then returns a response carrying read data and a miss/unaligned flag.
module virtual_slave_bfm
  import virtual_slave_bfm_pkg::*;
#(
  parameter string       C_BUS_TITLE = "virtual_slave",
  parameter logic [31:0] C_BASE_ADDR = 32'h0000_0000,
  parameter int unsigned C_ADDR_BITS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  virtual_slave_bfm_if.slave     bus,
  output logic                   we,
  output logic [C_ADDR_BITS-1:0] waddr,
  output logic [DATA_W-1:0]      wdata,
  output logic                   re,
  output logic [C_ADDR_BITS-1:0] raddr,
  input  logic [DATA_W-1:0]      rdata
);

  state_e                 state_q, state_d;
  logic                   write_q, write_d;
  logic                   err_q, err_d;
  logic                   we_q, we_d;
  logic                   re_q, re_d;
  logic [C_ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [C_ADDR_BITS-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;

  logic                   req_ready;
  logic                   accept;
  logic                   req_err;
  logic [C_ADDR_BITS-1:0] offset;

  // Gated by rst so the bus sees "not ready" for the whole reset period.
  assign req_ready = (state_q == StIdle) && !rst;
  assign accept    = bus.req_valid && req_ready;
  assign req_err   = !addr_hit(bus.req_addr, C_BASE_ADDR, C_ADDR_BITS) ||
                     (bus.req_addr[1:0] != 2'b00);
  assign offset    = bus.req_addr[C_ADDR_BITS-1:0];

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    err_d       = err_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          write_d = bus.req_write;
          err_d   = req_err;
          state_d = StStrobe;
          // Strobes are registered so they are high exactly in the STROBE cycle.
          if (!req_err) begin
            if (bus.req_write) begin
              we_d    = 1'b1;
              waddr_d = offset;
              wdata_d = bus.req_wdata;
            end else begin
              re_d    = 1'b1;
              raddr_d = offset;
            end
          end
        end
      end
      StStrobe: begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_rdata_d = (!write_q && !err_q) ? rdata : '0;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      err_q       <= err_d;
      we_q        <= we_d;
      re_q        <= re_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (accept && req_err) begin
      $display("%s: error access addr=%h %s", C_BUS_TITLE, bus.req_addr,
               bus.req_write ? "write" : "read");
    end
  end
`endif

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign we            = we_q;
  assign re            = re_q;
  assign waddr         = waddr_q;
  assign raddr         = raddr_q;
  assign wdata         = wdata_q;

endmodule

// File: tb/tb_virtual_slave_bfm.sv
// Scoreboard bench for virtual_slave_bfm: expected strobes and responses are
// queued by the driver and retired by negedge monitors.
module tb_virtual_slave_bfm;

  typedef struct packed {
    logic        w;
    logic [9:0]  a;
    logic [31:0] d;
  } strobe_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, re;
  logic [9:0]  waddr, raddr;
  logic [31:0] wdata;
  logic [31:0] rdata_in;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc, acc_prev, hs_cyc;

  strobe_t exp_strb[$];
  rsp_t    exp_rsp[$];
  strobe_t mon_s;
  rsp_t    mon_r;

  virtual_slave_bfm_if bus ();

  virtual_slave_bfm #(
    .C_BUS_TITLE("tb_slave"),
    .C_BASE_ADDR(32'h0001_0000),
    .C_ADDR_BITS(10)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .re   (re),
    .raddr(raddr),
    .rdata(rdata_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (exp_rsp.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_r = exp_rsp.pop_front();
        chk("rsp_err", 32'(bus.rsp_err), 32'(mon_r.err));
        chk("rsp_rdata", bus.rsp_rdata, mon_r.rd);
      end
    end
  end

  // Strobe monitor: each cycle with WE/RE high retires one expected strobe.
  always @(negedge clk) begin
    if (we === 1'b1 || re === 1'b1) begin
      if (exp_strb.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        mon_s = exp_strb.pop_front();
        chk("strobe_both", 32'(we && re), 32'd0);
        chk("strobe_dir", 32'(we), 32'(mon_s.w));
        if (mon_s.w) begin
          chk("waddr", 32'(waddr), 32'(mon_s.a));
          chk("wdata", wdata, mon_s.d);
        end else begin
          chk("raddr", 32'(raddr), 32'(mon_s.a));
        end
      end
    end
  end

  // Issue one request; called and returning at posedge+1.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic exp_err, input logic [31:0] exp_rd, input logic push_rsp);
    int n;
    strobe_t s;
    rsp_t r;
    if (!exp_err) begin
      s.w = w;
      s.a = a[9:0];
      s.d = d;
      exp_strb.push_back(s);
    end
    if (push_rsp) begin
      r.err = exp_err;
      r.rd  = exp_rd;
      exp_rsp.push_back(r);
    end
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || exp_strb.size() != 0) && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 30) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    rdata_in      = 32'h0000_6000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_we_re", {30'd0, we, re}, 32'd0);
    chk("rst_waddr_raddr", {12'd0, waddr, raddr}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;

    send(1'b1, 32'h0001_0004, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
    wait_done();
    send(1'b0, 32'h0001_000C, 32'hFFFF_FFFF, 1'b0, 32'h0000_6000, 1'b1);
    wait_done();
    send(1'b1, 32'h0001_0400, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b1);
    wait_done();
    send(1'b0, 32'h0000_FFFC, 32'h0, 1'b1, 32'h0, 1'b1);
    wait_done();
    send(1'b1, 32'h0001_0002, 32'h5555_AAAA, 1'b1, 32'h0, 1'b1);
    wait_done();
    chk("waddr_hold", 32'(waddr), 32'h004);
    chk("wdata_hold", wdata, 32'h1234_5678);
    chk("raddr_hold", 32'(raddr), 32'h00C);

    // Window edges, back to back to measure throughput.
    send(1'b1, 32'h0001_03FC, 32'hA5A5_5A5A, 1'b0, 32'h0, 1'b1);
    acc_prev = acc_cyc;
    send(1'b0, 32'h0001_0000, 32'h0, 1'b0, 32'h0000_6000, 1'b1);
    chk("throughput", acc_cyc - acc_prev, 32'd3);
    wait_done();

    // Backpressure: response held for 3 cycles while RDATA changes underneath.
    bus.rsp_ready = 1'b0;
    rdata_in      = 32'h0BAD_F00D;
    send(1'b0, 32'h0001_0008, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b1);
    @(posedge clk);
    #1 rdata_in = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 32'h0BAD_F00D);
      chk("bp_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      if (i < 2) @(posedge clk);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(posedge clk);
    hs_cyc = cyc;
    #1;
    rdata_in = 32'h0000_6000;
    send(1'b0, 32'h0001_0010, 32'h0, 1'b0, 32'h0000_6000, 1'b1);
    chk("accept_after_hs", acc_cyc - hs_cyc, 32'd1);
    wait_done();

    // Reset in the STROBE cycle: strobe seen once, then no response.
    send(1'b1, 32'h0001_0020, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_we", 32'(we), 32'd0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
    chk("abort_waddr", 32'(waddr), 32'd0);
    chk("abort_wdata", wdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", 32'(bus.req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    chk("strobe_queue_empty", 32'(exp_strb.size()), 32'd0);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
